// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: serial subtractor state encoding and default width.
package arith_pkg;

  localparam int SUB_WIDTH = 8;

  typedef enum logic [1:0] {
    SUB_IDLE  = 2'd0,
    SUB_SHIFT = 2'd1,
    SUB_DONE  = 2'd2
  } sub_state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result valid-ready bundle for the bit-serial subtractor.
interface serial_subtractor_if
  import arith_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             overflow;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow, overflow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow, overflow
  );
endinterface

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
  input  logic in1,
  input  logic in2,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = in1 ^ in2 ^ cin;
  assign cout = (in1 & in2) | (in1 & cin) | (in2 & cin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first, one full_adder reused each cycle.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH
) (
  input logic          clk,
  input logic          rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  sub_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr, res, res_next;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q, overflow_q;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             sum, cout;
  logic             accept, last;

  // a + ~b + 1: the initial carry of 1 supplies the +1, cout means "no borrow"
  full_adder u_fa (
    .in1  (a_sr[0]),
    .in2  (~b_sr[0]),
    .cin  (carry),
    .sum  (sum),
    .cout (cout)
  );

  generate
    if (WIDTH == 1) begin : g_res1
      assign res_next = sum;
    end else begin : g_resn
      assign res_next = {sum, res[WIDTH-1:1]};
    end
  endgenerate

  assign accept = (state_q == SUB_IDLE) && bus.in_valid;
  assign last   = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SUB_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SUB_IDLE:  if (bus.in_valid)  state_d = SUB_SHIFT;
      SUB_SHIFT: if (last)          state_d = SUB_DONE;
      SUB_DONE:  if (bus.out_ready) state_d = SUB_IDLE;
      default:                      state_d = SUB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr       <= '0;
      b_sr       <= '0;
      res        <= '0;
      carry      <= 1'b0;
      cnt        <= '0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else if (accept) begin
      a_sr  <= bus.a;
      b_sr  <= bus.b;
      carry <= 1'b1;
      cnt   <= '0;
    end else if (state_q == SUB_SHIFT) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      res   <= res_next;
      carry <= cout;
      cnt   <= cnt + CNT_W'(1);
      // result outputs hold the previous operation until this one completes
      if (last) begin
        diff_q     <= res_next;
        borrow_q   <= ~cout;
        overflow_q <= carry ^ cout;
      end
    end
  end

  assign bus.in_ready  = (state_q == SUB_IDLE);
  assign bus.out_valid = (state_q == SUB_DONE);
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized check of serial_subtractor (WIDTH 8 and 1) against an arithmetic reference model.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) i8 ();
  serial_subtractor_if #(.WIDTH(1)) i1 ();

  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(i8));
  serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(i1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input int w, input int ua, input int ub,
                                output logic [31:0] d, output logic br, output logic ov);
    int sa, sb, sd;
    d  = 32'((ua - ub) & ((1 << w) - 1));
    br = (ua < ub);
    sa = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
    sb = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
    sd = sa - sb;
    ov = (sd > (1 << (w - 1)) - 1) || (sd < -(1 << (w - 1)));
  endfunction

  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input int hold);
    int n;
    logic [31:0] ed;
    logic eb, eo;
    model(8, int'(a), int'(b), ed, eb, eo);
    @(negedge clk);
    check("w8_in_ready_idle", 32'(i8.in_ready), 32'd1);
    i8.a = a; i8.b = b; i8.in_valid = 1'b1; i8.out_ready = 1'b0;
    @(posedge clk); #1;
    i8.in_valid = 1'b0; i8.a = 8'($urandom); i8.b = 8'($urandom);
    n = 0;
    while (!i8.out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("w8_latency", 32'(n), 32'd8);
    for (int i = 0; i < hold; i++) begin
      i8.in_valid = 1'b1; i8.a = 8'($urandom); i8.b = 8'($urandom);
      check("w8_hold_in_ready", 32'(i8.in_ready), 32'd0);
      check("w8_hold_diff", 32'(i8.diff), ed);
      @(posedge clk); #1;
    end
    check("w8_out_valid", 32'(i8.out_valid), 32'd1);
    check("w8_diff", 32'(i8.diff), ed);
    check("w8_borrow", 32'(i8.borrow), 32'(eb));
    check("w8_overflow", 32'(i8.overflow), 32'(eo));
    i8.out_ready = 1'b1;
    @(posedge clk); #1;
    i8.out_ready = 1'b0; i8.in_valid = 1'b0;
    check("w8_post_out_valid", 32'(i8.out_valid), 32'd0);
    check("w8_post_in_ready", 32'(i8.in_ready), 32'd1);
    check("w8_post_diff_kept", 32'(i8.diff), ed);
  endtask

  task automatic do_op1(input logic a, input logic b);
    int n;
    logic [31:0] ed;
    logic eb, eo;
    model(1, int'(a), int'(b), ed, eb, eo);
    @(negedge clk);
    i1.a = a; i1.b = b; i1.in_valid = 1'b1; i1.out_ready = 1'b0;
    @(posedge clk); #1;
    i1.in_valid = 1'b0; i1.a = ~a; i1.b = ~b;
    n = 0;
    while (!i1.out_valid && n < 10) begin
      @(posedge clk); #1; n++;
    end
    check("w1_latency", 32'(n), 32'd1);
    check("w1_diff", 32'(i1.diff), ed);
    check("w1_borrow", 32'(i1.borrow), 32'(eb));
    check("w1_overflow", 32'(i1.overflow), 32'(eo));
    i1.out_ready = 1'b1;
    @(posedge clk); #1;
    i1.out_ready = 1'b0;
    check("w1_post_in_ready", 32'(i1.in_ready), 32'd1);
  endtask

  initial begin
    i8.in_valid = 1'b0; i8.a = '0; i8.b = '0; i8.out_ready = 1'b0;
    i1.in_valid = 1'b0; i1.a = '0; i1.b = '0; i1.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(i8.in_ready), 32'd1);
    check("rst_out_valid", 32'(i8.out_valid), 32'd0);
    check("rst_diff", 32'(i8.diff), 32'd0);

    do_op8(8'd10, 8'd3, 0);
    do_op8(8'd3, 8'd10, 1);
    do_op8(8'h80, 8'h01, 0);
    do_op8(8'h7F, 8'hFF, 0);
    do_op8(8'h00, 8'h00, 0);
    do_op8(8'd10, 8'd3, 5);
    do_op8(8'h55, 8'hAA, 0);
    for (int k = 0; k < 20; k++)
      do_op8(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));

    // reset in the middle of a shift aborts and clears results
    @(negedge clk);
    i8.a = 8'h80; i8.b = 8'h01; i8.in_valid = 1'b1;
    @(posedge clk); #1;
    i8.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("arst_out_valid", 32'(i8.out_valid), 32'd0);
    check("arst_in_ready", 32'(i8.in_ready), 32'd1);
    check("arst_diff", 32'(i8.diff), 32'd0);
    check("arst_borrow", 32'(i8.borrow), 32'd0);
    check("arst_overflow", 32'(i8.overflow), 32'd0);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("arst_no_result", 32'(i8.out_valid), 32'd0);
    do_op8(8'd3, 8'd10, 0);

    do_op1(1'b0, 1'b1);
    do_op1(1'b1, 1'b0);
    do_op1(1'b0, 1'b0);
    do_op1(1'b1, 1'b1);
    for (int k = 0; k < 6; k++)
      do_op1(1'($urandom), 1'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
